// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared binary32 field widths, field struct and special
//               encodings for the floating-point datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fp_lzc
// Description : 27-bit leading-zero counter for the adder normalize step.
//               Purely combinational; an all-zero input reports 27.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc (
    input  logic [26:0] i_value,
    output logic [4:0]  o_count
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        o_count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_value[i]) begin
                o_count = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
// Module      : fp_add
// Description : Single-precision IEEE-754 adder, round-to-nearest-even,
//               one combinational stage feeding a single output register.
//               Denormal inputs flush to zero; overflow saturates to Inf.
//               Optional macro FP_ADD_SPECIALS_EN enables Inf/NaN handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A_FP,
    input  logic [31:0] B_FP,
    output logic        sign,
    output logic [7:0]  exponent,
    output logic [22:0] mantissa
);

    fp32_t       w_a, w_b, w_big, w_small;
    logic        w_a_zero, w_b_zero, w_a_first, w_eff_sub;
    logic [30:0] w_mag_a, w_mag_b;
    logic [7:0]  w_diff;
    logic [26:0] w_big_sig, w_small_sig, w_shifted, w_mask, w_aligned;
    logic        w_sticky;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic signed [9:0] w_exp_norm, w_exp_rnd;
    logic        w_round_up;
    logic [24:0] w_rnd;
    logic [22:0] w_frac_rnd;
    fp32_t       w_res;

    assign w_a      = A_FP;
    assign w_b      = B_FP;
    assign w_a_zero = (w_a.exp == 8'd0);
    assign w_b_zero = (w_b.exp == 8'd0);
    // Denormals compare as zero; ties keep A as the larger operand
    assign w_mag_a   = w_a_zero ? 31'd0 : {w_a.exp, w_a.frac};
    assign w_mag_b   = w_b_zero ? 31'd0 : {w_b.exp, w_b.frac};
    assign w_a_first = (w_mag_a >= w_mag_b);

    // Swap, align the smaller significand (3 extra bits: guard/round/sticky) and add
    always_comb begin
        w_big       = w_a_first ? w_a : w_b;
        w_small     = w_a_first ? w_b : w_a;
        w_big_sig   = {1'b1, w_big.frac, 3'b000};
        w_small_sig = (w_small.exp == 8'd0) ? 27'd0 : {1'b1, w_small.frac, 3'b000};
        w_diff      = w_big.exp - w_small.exp;
        w_shifted   = w_small_sig >> w_diff;
        w_mask      = ~(27'h7FF_FFFF << w_diff);
        w_sticky    = |(w_small_sig & w_mask);
        if (w_diff >= 8'd26) begin
            w_aligned = {26'd0, |w_small_sig};
        end else begin
            w_aligned = w_shifted | {26'd0, w_sticky};
        end
        w_eff_sub = w_big.sign ^ w_small.sign;
        if (w_eff_sub) begin
            w_sum = {1'b0, w_big_sig} - {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_big_sig} + {1'b0, w_aligned};
        end
    end

    fp_lzc u_lzc (
        .i_value (w_sum[26:0]),
        .o_count (w_lz)
    );

    // Normalize, round to nearest even, then apply zero/overflow/special overrides
    always_comb begin
        if (w_sum[27]) begin
            // Carry-out: drop one bit into the sticky position
            w_norm     = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp_norm = $signed({2'b00, w_big.exp}) + 10'sd1;
        end else begin
            w_norm     = w_sum[26:0] << w_lz;
            w_exp_norm = $signed({2'b00, w_big.exp}) - $signed({5'd0, w_lz});
        end
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
        if (w_rnd[24]) begin
            w_frac_rnd = w_rnd[23:1];
            w_exp_rnd  = w_exp_norm + 10'sd1;
        end else begin
            w_frac_rnd = w_rnd[22:0];
            w_exp_rnd  = w_exp_norm;
        end

        if (w_sum == 28'd0) begin
            // Exact cancellation always yields +0
            w_res = '0;
        end else if (w_exp_rnd >= 10'sd255) begin
            w_res = {w_big.sign, FP_POS_INF[30:0]};
        end else if (w_exp_norm <= 10'sd0) begin
            w_res = {w_big.sign, 31'd0};
        end else begin
            w_res = {w_big.sign, w_exp_rnd[7:0], w_frac_rnd};
        end

        if (w_a_zero && w_b_zero) begin
            w_res = {w_a.sign & w_b.sign, 31'd0};
        end else if (w_a_zero) begin
            w_res = w_b;
        end else if (w_b_zero) begin
            w_res = w_a;
        end

`ifdef FP_ADD_SPECIALS_EN
        if (((w_a.exp == 8'hFF) && (w_a.frac != 23'd0)) ||
            ((w_b.exp == 8'hFF) && (w_b.frac != 23'd0))) begin
            w_res = FP_QNAN;
        end else if ((w_a.exp == 8'hFF) && (w_b.exp == 8'hFF)) begin
            w_res = (w_a.sign == w_b.sign) ? w_a : FP_QNAN;
        end else if (w_a.exp == 8'hFF) begin
            w_res = w_a;
        end else if (w_b.exp == 8'hFF) begin
            w_res = w_b;
        end
`endif
    end

    // Output register: the only state in the adder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign     <= 1'b0;
            exponent <= 8'd0;
            mantissa <= 23'd0;
        end else begin
            sign     <= w_res.sign;
            exponent <= w_res.exp;
            mantissa <= w_res.frac;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add
// Description : Scoreboard bench for fp_add: directed operand pairs with
//               hand-computed sums, async reset and back-to-back throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A_FP  = 32'd0;
    logic [31:0] B_FP  = 32'd0;
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    logic in_valid = 1'b0;

    localparam int N1 = 8;
    localparam int N2 = 8;

    logic [31:0] tbl1 [N1][3] = '{
        '{32'h40E80000, 32'h3EC00000, 32'h40F40000},
        '{32'h40C00000, 32'h40E00000, 32'h41500000},
        '{32'hC0E00000, 32'hC0400000, 32'hC1200000},
        '{32'h40E00000, 32'hC0400000, 32'h40800000},
        '{32'hC0E00000, 32'h40400000, 32'hC0800000},
        '{32'h42820000, 32'hC27C0000, 32'h40000000},
        '{32'h40400000, 32'hC0400000, 32'h00000000},
        '{32'h3F800000, 32'h33800000, 32'h3F800000}
    };

    logic [31:0] tbl2 [N2][3] = '{
        '{32'h3F800001, 32'h33800000, 32'h3F800002},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
        '{32'h00000000, 32'hBF800000, 32'hBF800000},
        '{32'h80000000, 32'h80000000, 32'h80000000},
        '{32'h80000000, 32'h00000000, 32'h00000000},
        '{32'h00000001, 32'h3F800000, 32'h3F800000},
        '{32'h4B800000, 32'h40000000, 32'h4B800001},
        '{32'h80800001, 32'h00800000, 32'h80000000}
    };

    fp_add dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A_FP     (A_FP),
        .B_FP     (B_FP),
        .sign     (sign),
        .exponent (exponent),
        .mantissa (mantissa)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        @(negedge clk);
        A_FP     = a;
        B_FP     = b;
        in_valid = 1'b1;
        v.a = a; v.b = b; v.exp = e;
        sb_q.push_back(v);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({sign, exponent, mantissa} !== 32'd0) begin
            errors++;
            $display("FAIL %s: got %08h expected 00000000", name, {sign, exponent, mantissa});
        end
    endtask

    // Monitor: a pair sampled at a posedge has its result checked 1 time unit later
    initial begin
        logic v;
        vec_t e;
        forever begin
            @(posedge clk);
            v = in_valid;
            #1;
            if (v) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got %08h expected none", {sign, exponent, mantissa});
                end else begin
                    e = sb_q.pop_front();
                    if ({sign, exponent, mantissa} !== e.exp) begin
                        errors++;
                        $display("FAIL add %08h+%08h: got %08h expected %08h",
                                 e.a, e.b, {sign, exponent, mantissa}, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N1; i++) begin
            issue(tbl1[i][0], tbl1[i][1], tbl1[i][2]);
        end
        go_idle();
        @(negedge clk);

        // Asynchronous reset between clock edges while the output is non-zero
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N2; i++) begin
            issue(tbl2[i][0], tbl2[i][1], tbl2[i][2]);
        end
`ifdef FP_ADD_SPECIALS_EN
        issue(32'h7F800000, 32'hFF800000, 32'h7FC00000);
        issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        issue(32'hFF800000, 32'h3F800000, 32'hFF800000);
`endif
        go_idle();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
